// File: rtl/reduce_sched.sv
// reduce_sched: round-robin scheduler sharing one registered bitwise-reduction
// unit (AND/OR/XOR/NAND/NOR) among N requesters, answering over a valid/ready
// response channel tagged with the requester id.
// Optional feature macro: REDUCE_SCHED_XNOR_EN adds opcode 5 = XNOR reduction.
module reduce_sched #(
    parameter int N = 4,
    parameter int W = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*W-1:0]  req_x,
    input  logic [N*3-1:0]  req_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_y,
    output logic [IW-1:0]   rsp_id,
    output logic            rsp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_ID = IW'(N - 1);

    state_t          state_r;
    state_t          state_next_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   win_s;
    logic            found_s;
    logic [IW:0]     idx_s;
    logic [N-1:0]    grant_oh_s;
    logic [W-1:0]    x_r;
    logic [2:0]      op_r;
    logic [IW-1:0]   gid_r;
    logic            rsp_valid_r;
    logic            rsp_y_r;
    logic            rsp_err_r;
    logic [IW-1:0]   rsp_id_r;
    logic            busy_r;
    logic            grant_s;

    // Reduction unit: returns {err, y}. Operand X/Z bits flow through the
    // reduction operators untouched.
    function automatic logic [1:0] reduce_fn(input logic [W-1:0] x, input logic [2:0] op);
        logic [1:0] r;
        case (op)
            3'd0:    r = {1'b0, &x};
            3'd1:    r = {1'b0, |x};
            3'd2:    r = {1'b0, ^x};
            3'd3:    r = {1'b0, ~&x};
            3'd4:    r = {1'b0, ~|x};
`ifdef REDUCE_SCHED_XNOR_EN
            3'd5:    r = {1'b0, ~^x};
`endif
            default: r = {1'b1, 1'b0};
        endcase
        return r;
    endfunction

    // Round-robin search: first valid index starting at ptr, wrapping mod N.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s   = {1'b0, ptr_r} + (IW+1)'(k);
            idx_s   = (idx_s >= (IW+1)'(N)) ? (idx_s - (IW+1)'(N)) : idx_s;
            win_s   = (req_valid[idx_s[IW-1:0]] && !found_s) ? idx_s[IW-1:0] : win_s;
            found_s = found_s | req_valid[idx_s[IW-1:0]];
        end
    end

    assign grant_s = (state_r == IDLE) && found_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: state_next_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: one-hot accept for the winner, only while IDLE and out of reset.
    always_comb begin
        grant_oh_s        = '0;
        grant_oh_s[win_s] = 1'b1;
        if (grant_s && !rst) begin
            req_ready = grant_oh_s;
        end else begin
            req_ready = '0;
        end
    end

    // Status flags tracking the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            busy_r      <= (state_next_s != IDLE);
            rsp_valid_r <= (state_next_s == RESP);
        end
    end

    // Grant capture: latch the winner's operand/opcode/id and advance the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r   <= '0;
            op_r  <= 3'd0;
            gid_r <= '0;
            ptr_r <= '0;
        end else if (grant_s) begin
            x_r   <= req_x[win_s*W +: W];
            op_r  <= req_op[win_s*3 +: 3];
            gid_r <= win_s;
            ptr_r <= (win_s == LAST_ID) ? '0 : (win_s + IW'(1));
        end else begin
            x_r   <= x_r;
            op_r  <= op_r;
            gid_r <= gid_r;
            ptr_r <= ptr_r;
        end
    end

    // Result register: evaluated once in EXEC and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y_r   <= 1'b0;
            rsp_err_r <= 1'b0;
            rsp_id_r  <= '0;
        end else if (state_r == EXEC) begin
            {rsp_err_r, rsp_y_r} <= reduce_fn(x_r, op_r);
            rsp_id_r             <= gid_r;
        end else begin
            rsp_y_r   <= rsp_y_r;
            rsp_err_r <= rsp_err_r;
            rsp_id_r  <= rsp_id_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_y     = rsp_y_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_reduce_sched.sv
// Directed testbench for reduce_sched (N=4, W=4): a vector table for single
// requests plus hand-written sequences for rotation, backpressure, X/Z
// operands and reset in the middle of a response.
module tb_reduce_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_x;
    logic [N*3-1:0]  req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_y;
    logic [1:0]      rsp_id;
    logic            rsp_err;
    logic            busy;

    int n_checks;
    int n_fail;

    typedef struct {
        int         id;
        logic [3:0] x;
        logic [2:0] op;
        logic [3:0] rdy;
        logic       y;
        logic       err;
    } vec_t;

    vec_t tbl[13];

    reduce_sched #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request from an IDLE start point (called at posedge+1), rsp_ready high.
    task automatic run_req(input int id, input logic [3:0] x, input logic [2:0] op,
                           input logic [3:0] rdy, input logic y, input logic err);
        rsp_ready            = 1'b1;
        req_valid            = 4'b0000;
        req_valid[id]        = 1'b1;
        req_x[id*W +: W]     = x;
        req_op[id*3 +: 3]    = op;
        #1;
        check("idle_ready", 32'(req_ready), 32'(rdy));
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_y", 32'(rsp_y), 32'(y));
        check("resp_id", 32'(rsp_id), 32'(id));
        check("resp_err", 32'(rsp_err), 32'(err));
        @(posedge clk); #1;
        check("after_hs_valid", 32'(rsp_valid), 32'd0);
        check("after_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] xv;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_x     = 16'h0000;
        req_op    = 12'h000;
        rsp_ready = 1'b1;

        tbl[0]  = '{2, 4'b1001, 3'd0, 4'b0100, 1'b0, 1'b0};
        tbl[1]  = '{0, 4'b1001, 3'd0, 4'b0001, 1'b0, 1'b0};
        tbl[2]  = '{0, 4'b1001, 3'd1, 4'b0001, 1'b1, 1'b0};
        tbl[3]  = '{0, 4'b1001, 3'd2, 4'b0001, 1'b0, 1'b0};
        tbl[4]  = '{0, 4'b1001, 3'd3, 4'b0001, 1'b1, 1'b0};
        tbl[5]  = '{0, 4'b1001, 3'd4, 4'b0001, 1'b0, 1'b0};
`ifdef REDUCE_SCHED_XNOR_EN
        tbl[6]  = '{0, 4'b1001, 3'd5, 4'b0001, 1'b1, 1'b0};
`else
        tbl[6]  = '{0, 4'b1001, 3'd5, 4'b0001, 1'b0, 1'b1};
`endif
        tbl[7]  = '{0, 4'b1001, 3'd6, 4'b0001, 1'b0, 1'b1};
        tbl[8]  = '{0, 4'b1111, 3'd7, 4'b0001, 1'b0, 1'b1};
        tbl[9]  = '{3, 4'b1111, 3'd0, 4'b1000, 1'b1, 1'b0};
        tbl[10] = '{1, 4'b0000, 3'd4, 4'b0010, 1'b1, 1'b0};
        tbl[11] = '{3, 4'b0111, 3'd2, 4'b1000, 1'b1, 1'b0};
        tbl[12] = '{1, 4'b0000, 3'd3, 4'b0010, 1'b1, 1'b0};

        // Reset state, including req_ready suppressed while reset is held.
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'b1111;
        req_x     = 16'h3210;   // lane i operand = i
        req_op    = {3'd1, 3'd1, 3'd1, 3'd1};
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin with all four valid: grants 0,1,2,3,0, three cycles apart.
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clk); #1;
            check("rr_exec_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            check("rr_valid", 32'(rsp_valid), 32'd1);
            check("rr_id", 32'(rsp_id), 32'(k % 4));
            check("rr_y", 32'(rsp_y), 32'((k % 4) != 0));
            @(posedge clk);
        end
        #1;
        req_valid = 4'b0000;

        // Table-driven single requests.
        for (int i = 0; i < 13; i++) begin
            run_req(tbl[i].id, tbl[i].x, tbl[i].op, tbl[i].rdy, tbl[i].y, tbl[i].err);
        end

        // Backpressure: hold RESP for 5 cycles with requester 1 waiting.
        rsp_ready   = 1'b0;
        req_valid   = 4'b0001;
        req_x[3:0]  = 4'b1001;
        req_op[2:0] = 3'd1;
        #1;
        check("bp_ready0", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid   = 4'b0010;
        req_x[7:4]  = 4'b1111;
        req_op[5:3] = 3'd0;
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
            check("bp_hold_y", 32'(rsp_y), 32'd1);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_ready", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        check("bp_r1_valid", 32'(rsp_valid), 32'd1);
        check("bp_r1_id", 32'(rsp_id), 32'd1);
        check("bp_r1_y", 32'(rsp_y), 32'd1);
        @(posedge clk); #1;

        // X/Z operands follow reduction semantics.
        xv = 4'bx111;
        run_req(0, xv, 3'd0, 4'b0001, &xv, 1'b0);
        xv = 4'bz001;
        run_req(2, xv, 3'd1, 4'b0100, 1'b1, 1'b0);

        // Reset while in RESP: response dropped at once, ptr back to 0.
        rsp_ready    = 1'b0;
        req_valid    = 4'b0100;
        req_x[11:8]  = 4'b1111;
        req_op[8:6]  = 3'd2;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        check("mid_valid", 32'(rsp_valid), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        req_valid     = 4'b1001;
        req_x[3:0]    = 4'b0000;
        req_op[2:0]   = 3'd4;
        req_x[15:12]  = 4'b1111;
        req_op[11:9]  = 3'd0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("post_rst_rsp_y", 32'(rsp_y), 32'd1);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
